// File: rtl/datamem_stage.sv
// ============================================================================
//  Module   : datamem_stage
//  Purpose  : MEM stage of the 5-stage MIPS pipeline; word load/store against
//             an internal RAM with configurable access latency and stall.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module datamem_stage #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mwmem,
    input  logic        mm2reg,
    input  logic [31:0] malu_out,
    input  logic [31:0] mqb,
    output logic [31:0] mdo,
    output logic        mem_stall,
    output logic        mem_err
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_busy  = 1'b1;
    localparam bit         c_single   = (LATENCY == 1);
    localparam logic [2:0] c_cnt_init = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    logic [31:0]           r_mem [2**DEPTH_LOG2];
    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_nxt;
    logic                  w_sel;
    logic                  w_aligned;
    logic                  w_req;
    logic                  w_done;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign w_sel     = mwmem | mm2reg;
    assign w_aligned = (malu_out[1:0] == 2'b00);
    assign w_req     = w_sel & ~rst & w_aligned;
    assign w_idx     = malu_out[DEPTH_LOG2+1:2];

    // Address bits above the RAM index are ignored so accesses wrap.
    generate
        if (DEPTH_LOG2 < 30) begin : g_unused_addr
            logic w_unused_hi;
            assign w_unused_hi = &{1'b0, malu_out[31:DEPTH_LOG2+2]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_idle: begin
                if (w_req && !c_single) begin
                    w_state_nxt = c_st_busy;
                    w_cnt_nxt   = c_cnt_init;
                end
            end
            c_st_busy: begin
                if (r_cnt != 3'd0) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // Completion requires w_req, which folds in reset so a dropped store never writes.
    always_comb begin
        w_done    = 1'b0;
        mem_stall = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_req) begin
                    if (c_single) w_done    = 1'b1;
                    else          mem_stall = 1'b1;
                end
            end
            c_st_busy: begin
                if (!rst) begin
                    if (r_cnt != 3'd0) mem_stall = 1'b1;
                    else               w_done    = w_req;
                end
            end
            default: begin
                w_done    = 1'b0;
                mem_stall = 1'b0;
            end
        endcase
        mem_err = w_sel & ~w_aligned & ~rst;
        mdo     = (w_done && mm2reg) ? r_mem[w_idx] : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (w_done && mwmem) begin
            r_mem[w_idx] <= mqb;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_datamem_stage.sv
// ============================================================================
//  Module   : tb_datamem_stage
//  Purpose  : Self-checking bench for datamem_stage at latencies 1..4 against
//             a word-array reference memory.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_datamem_stage;

    localparam int c_lanes = 4;

    logic        clk;
    logic        rst_a      [c_lanes];
    logic        mwmem_a    [c_lanes];
    logic        mm2reg_a   [c_lanes];
    logic [31:0] addr_a     [c_lanes];
    logic [31:0] data_a     [c_lanes];
    logic [31:0] mdo_a      [c_lanes];
    logic        stall_a    [c_lanes];
    logic        err_a      [c_lanes];

    logic [31:0] ref_mem [c_lanes][256];
    bit          ref_ok  [c_lanes][256];

    int n_checks;
    int n_errors;

    // Lane g runs a DUT with LATENCY = g+1.
    generate
        for (genvar g = 0; g < c_lanes; g++) begin : g_dut
            datamem_stage #(.DEPTH_LOG2(8), .LATENCY(g + 1)) u_dut (
                .clk       (clk),
                .rst       (rst_a[g]),
                .mwmem     (mwmem_a[g]),
                .mm2reg    (mm2reg_a[g]),
                .malu_out  (addr_a[g]),
                .mqb       (data_a[g]),
                .mdo       (mdo_a[g]),
                .mem_stall (stall_a[g]),
                .mem_err   (err_a[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs(input int ln);
        mwmem_a[ln]  = 1'b0;
        mm2reg_a[ln] = 1'b0;
        addr_a[ln]   = 32'd0;
        data_a[ln]   = 32'd0;
    endtask

    // One memory instruction on lane ln; called just after a rising edge.
    task automatic access(input int ln, input bit wr, input bit rd,
                          input logic [31:0] addr, input logic [31:0] data);
        int          lat;
        int unsigned idx;
        logic [31:0] old;
        bit          known;
        lat   = ln + 1;
        idx   = (addr / 4) % 256;
        old   = ref_mem[ln][idx];
        known = ref_ok[ln][idx];
        mwmem_a[ln]  = wr;
        mm2reg_a[ln] = rd;
        addr_a[ln]   = addr;
        data_a[ln]   = data;
        if (addr % 4 != 0) begin
            @(negedge clk);
            chk("err_mis",   err_a[ln],   32'(1));
            chk("stall_mis", stall_a[ln], 32'(0));
            chk("mdo_mis",   mdo_a[ln],   32'd0);
            @(posedge clk); #1;
        end else begin
            for (int k = 0; k < lat; k++) begin
                @(negedge clk);
                chk("stall", stall_a[ln], 32'(k < lat - 1));
                chk("err",   err_a[ln],   32'(0));
                if (k < lat - 1 || !rd) chk("mdo_idle", mdo_a[ln], 32'd0);
                else if (known)         chk("mdo_load", mdo_a[ln], old);
                @(posedge clk); #1;
            end
            if (wr) begin
                ref_mem[ln][idx] = data;
                ref_ok[ln][idx]  = 1'b1;
            end
        end
        clear_inputs(ln);
    endtask

    task automatic idle_cycle(input int ln);
        @(negedge clk);
        chk("idle_stall", stall_a[ln], 32'(0));
        chk("idle_err",   err_a[ln],   32'(0));
        chk("idle_mdo",   mdo_a[ln],   32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          op;
        n_checks = 0;
        n_errors = 0;
        for (int l = 0; l < c_lanes; l++) begin
            for (int w = 0; w < 256; w++) ref_ok[l][w] = 1'b0;
            clear_inputs(l);
            rst_a[l] = 1'b1;
        end
        // Requests presented under reset must neither stall nor write.
        for (int l = 0; l < c_lanes; l++) begin
            mwmem_a[l]  = 1'b1;
            mm2reg_a[l] = 1'b1;
            addr_a[l]   = 32'h0000_0080;
        end
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        for (int l = 0; l < c_lanes; l++) begin
            chk("rst_stall", stall_a[l], 32'(0));
            chk("rst_err",   err_a[l],   32'(0));
            chk("rst_mdo",   mdo_a[l],   32'd0);
        end
        @(posedge clk); #1;
        for (int l = 0; l < c_lanes; l++) begin
            clear_inputs(l);
            rst_a[l] = 1'b0;
        end
        for (int l = 0; l < c_lanes; l++) idle_cycle(l);

        // Latency 2: store then load back-to-back, then misaligned store.
        access(1, 1, 0, 32'h10, 32'hDEADBEEF);
        access(1, 0, 1, 32'h10, 32'h0);
        access(1, 1, 0, 32'h13, 32'hCAFEF00D);
        access(1, 0, 1, 32'h10, 32'h0);
        // Address wrap and simultaneous store+load.
        access(1, 1, 0, 32'h400, 32'hA5A5_0001);
        access(1, 0, 1, 32'h000, 32'h0);
        access(1, 1, 1, 32'h000, 32'h0BAD_CAFE);
        access(1, 0, 1, 32'h800, 32'h0);

        // Latency 1: consecutive store/load without stalls.
        access(0, 1, 0, 32'h20, 32'h00000055);
        access(0, 0, 1, 32'h20, 32'h0);

        // Latency 4 load.
        access(3, 1, 0, 32'h44, 32'h1357_9BDF);
        access(3, 0, 1, 32'h44, 32'h0);

        // Latency 3: reset during first BUSY cycle of a store drops the write.
        access(2, 1, 0, 32'h40, 32'hAAAA_5555);
        mwmem_a[2] = 1'b1;
        addr_a[2]  = 32'h40;
        data_a[2]  = 32'h1234_5678;
        @(negedge clk);
        chk("rst_busy_stall0", stall_a[2], 32'(1));
        @(posedge clk); #1;
        rst_a[2] = 1'b1;
        @(negedge clk);
        chk("rst_busy_stall1", stall_a[2], 32'(0));
        @(posedge clk); #1;
        rst_a[2] = 1'b0;
        clear_inputs(2);
        idle_cycle(2);
        access(2, 0, 1, 32'h40, 32'h0);

        // Randomised traffic on every lane, concentrated on a few words.
        for (int l = 0; l < c_lanes; l++) begin
            for (int n = 0; n < 60; n++) begin
                op = $urandom_range(0, 9);
                a  = {$urandom_range(0, 255), 24'h0} | (32'($urandom_range(0, 15)) << 2);
                if (op == 9) a = a | 32'($urandom_range(1, 3));
                d  = $urandom;
                if (op < 4)       access(l, 1, 0, a, d);
                else if (op < 7)  access(l, 0, 1, a, d);
                else if (op < 8)  access(l, 1, 1, a, d);
                else if (op < 9)  idle_cycle(l);
                else              access(l, $urandom_range(0, 1) == 1, 1, a, d);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
